// File: rtl/column_drop_ctrl.sv
// rtl/column_drop_ctrl.sv - column occupancy, turn tracking and drop legality for the row finder
// Optional move counter: define DROP_MOVE_COUNT_EN to add the move_count output.
module column_drop_ctrl #(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clear,
  input  logic                drop_req,
  input  logic [2:0]          drop_col,
  output logic                busy,
  output logic                drop_valid,
  output logic                drop_reject,
  output logic [NUM_ROWS-1:0] onoff_val,
  output logic [2:0]          col_out,
  output logic                player,
  output logic                next_player,
  output logic                board_full
`ifdef DROP_MOVE_COUNT_EN
  ,
  output logic [5:0]          move_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_ANNOUNCE,
    S_REJECT
  } state_t;

  localparam logic [3:0] NUM_COLS_W = 4'(NUM_COLS);

  state_t              state_q;
  logic                drop_req_q;
  logic [2:0]          col_l_q;
  logic [NUM_ROWS-1:0] occ_q [NUM_COLS];
  logic [NUM_ROWS-1:0] onoff_q;
  logic [2:0]          col_out_q;
  logic                player_q;
  logic                next_player_q;
  logic                drop_valid_q;
  logic                drop_reject_q;

  logic                drop_edge;
  logic                col_oob;
  logic                all_full;
  logic [NUM_ROWS-1:0] occ_sel;
  logic [NUM_ROWS-1:0] occ_new;

`ifdef DROP_MOVE_COUNT_EN
  localparam logic [5:0] MAX_MOVES = 6'(NUM_COLS * NUM_ROWS);
  logic [5:0] move_count_q;
  assign move_count = move_count_q;
`endif

  assign drop_edge = drop_req & ~drop_req_q;
  assign col_oob   = {1'b0, col_l_q} >= NUM_COLS_W;
  assign occ_new   = {occ_sel[NUM_ROWS-2:0], 1'b1};

  // Select the latched column without indexing past the array, and AND the top bits for board_full
  always_comb begin
    occ_sel  = '0;
    all_full = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_l_q == 3'(c)) occ_sel = occ_q[c];
      all_full = all_full & occ_q[c][NUM_ROWS-1];
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign drop_valid  = drop_valid_q;
  assign drop_reject = drop_reject_q;
  assign onoff_val   = onoff_q;
  assign col_out     = col_out_q;
  assign player      = player_q;
  assign next_player = next_player_q;
  assign board_full  = all_full;

  // Drop FSM with occupancy storage and registered outputs; announce outputs load on entry to
  // ANNOUNCE so they are already valid during the drop_valid cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      drop_req_q    <= 1'b0;
      col_l_q       <= '0;
      onoff_q       <= '0;
      col_out_q     <= '0;
      player_q      <= 1'b0;
      next_player_q <= 1'b0;
      drop_valid_q  <= 1'b0;
      drop_reject_q <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) occ_q[c] <= '0;
`ifdef DROP_MOVE_COUNT_EN
      move_count_q  <= '0;
`endif
    end else begin
      drop_req_q    <= drop_req;
      drop_valid_q  <= 1'b0;
      drop_reject_q <= 1'b0;
      if (clear) begin
        state_q       <= S_IDLE;
        col_l_q       <= '0;
        onoff_q       <= '0;
        col_out_q     <= '0;
        player_q      <= 1'b0;
        next_player_q <= 1'b0;
        for (int c = 0; c < NUM_COLS; c++) occ_q[c] <= '0;
`ifdef DROP_MOVE_COUNT_EN
        move_count_q  <= '0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (drop_edge) begin
              col_l_q <= drop_col;
              state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (col_oob || occ_sel[NUM_ROWS-1] || all_full) begin
              drop_reject_q <= 1'b1;
              state_q       <= S_REJECT;
            end else begin
              state_q <= S_WRITE;
            end
          end
          S_WRITE: begin
            for (int c = 0; c < NUM_COLS; c++) begin
              if (col_l_q == 3'(c)) occ_q[c] <= occ_new;
            end
            onoff_q      <= occ_new;
            col_out_q    <= col_l_q;
            player_q     <= next_player_q;
            drop_valid_q <= 1'b1;
            state_q      <= S_ANNOUNCE;
          end
          S_ANNOUNCE: begin
            next_player_q <= ~next_player_q;
`ifdef DROP_MOVE_COUNT_EN
            if (move_count_q != MAX_MOVES) move_count_q <= move_count_q + 6'd1;
`endif
            state_q <= S_IDLE;
          end
          S_REJECT: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_column_drop_ctrl.sv
// tb/tb_column_drop_ctrl.sv - directed self-checking bench for column_drop_ctrl
module tb_column_drop_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic       drop_req = 1'b0;
  logic [2:0] drop_col = 3'd0;
  logic       busy;
  logic       drop_valid;
  logic       drop_reject;
  logic [5:0] onoff_val;
  logic [2:0] col_out;
  logic       player;
  logic       next_player;
  logic       board_full;
`ifdef DROP_MOVE_COUNT_EN
  logic [5:0] move_count;
`endif

  int errors = 0;
  int checks = 0;
  int vcnt = 0;
  int rcnt = 0;

  column_drop_ctrl #(.NUM_COLS(7), .NUM_ROWS(6)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .clear       (clear),
    .drop_req    (drop_req),
    .drop_col    (drop_col),
    .busy        (busy),
    .drop_valid  (drop_valid),
    .drop_reject (drop_reject),
    .onoff_val   (onoff_val),
    .col_out     (col_out),
    .player      (player),
    .next_player (next_player),
    .board_full  (board_full)
`ifdef DROP_MOVE_COUNT_EN
    ,
    .move_count  (move_count)
`endif
  );

  always #5 clock = ~clock;

  // Pulse counters sampled away from the active edge
  always @(negedge clock) begin
    if (drop_valid)  vcnt <= vcnt + 1;
    if (drop_reject) rcnt <= rcnt + 1;
  end

  // Issue one drop and report the first pulse and its latency in clock edges
  task automatic do_drop(input logic [2:0] col, output logic v, output logic r,
                         output int lat, output logic both);
    v = 1'b0; r = 1'b0; lat = 0; both = 1'b0;
    @(negedge clock);
    drop_col = col;
    drop_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (drop_valid && drop_reject) both = 1'b1;
      if (drop_valid || drop_reject) begin
        v = drop_valid;
        r = drop_reject;
        lat = i;
        break;
      end
    end
    for (int i = 0; i < 4 && busy; i++) @(negedge clock);
    drop_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, drop_valid, drop_reject, onoff_val, col_out, player, next_player, board_full} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {busy, drop_valid, drop_reject, onoff_val, col_out, player, next_player, board_full});
    end
    // Reset while the FSM sits in CHECK
    drop_col = 3'd2;
    drop_req = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_check: got %b want 1", busy); end
    resetn = 1'b0;
    drop_req = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b want 0", busy); end
    @(negedge clock);
    resetn = 1'b1;
    repeat (6) @(negedge clock);
    #1;
    checks++;
    if (vcnt !== 0 || rcnt !== 0) begin errors++; $display("FAIL reset_no_pulse: got v=%0d r=%0d want 0 0", vcnt, rcnt); end
    checks++;
    if ({busy, onoff_val, col_out, player, next_player, board_full} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b want 0", {busy, onoff_val, col_out, player, next_player, board_full});
    end
  endtask

  task automatic test_single_drop();
    logic v, r, both;
    int lat;
    do_drop(3'd3, v, r, lat, both);
    checks++;
    if (v !== 1'b1 || r !== 1'b0 || lat != 3) begin errors++; $display("FAIL single_latency: got v=%b r=%b lat=%0d want 1 0 3", v, r, lat); end
    checks++;
    if (onoff_val !== 6'b000001) begin errors++; $display("FAIL single_onoff: got %b want 000001", onoff_val); end
    checks++;
    if (col_out !== 3'd3) begin errors++; $display("FAIL single_col: got %0d want 3", col_out); end
    checks++;
    if (player !== 1'b0 || next_player !== 1'b1) begin errors++; $display("FAIL single_player: got p=%b np=%b want 0 1", player, next_player); end
    checks++;
    if (both !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got both=%b busy=%b want 0 0", both, busy); end
  endtask

  task automatic test_column_fill();
    logic v, r, both;
    int lat;
    logic [5:0] exp_occ;
    do_clear();
    exp_occ = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      exp_occ = {exp_occ[4:0], 1'b1};
      do_drop(3'd0, v, r, lat, both);
      checks++;
      if (v !== 1'b1 || lat != 3 || both !== 1'b0) begin errors++; $display("FAIL fill_valid_%0d: got v=%b lat=%0d want 1 3", i, v, lat); end
      checks++;
      if (onoff_val !== exp_occ || col_out !== 3'd0) begin errors++; $display("FAIL fill_onoff_%0d: got %b col %0d want %b col 0", i, onoff_val, col_out, exp_occ); end
      checks++;
      if (player !== 1'(i % 2)) begin errors++; $display("FAIL fill_player_%0d: got %b want %0d", i, player, i % 2); end
    end
    do_drop(3'd0, v, r, lat, both);
    checks++;
    if (r !== 1'b1 || v !== 1'b0 || lat != 2) begin errors++; $display("FAIL fill_reject: got v=%b r=%b lat=%0d want 0 1 2", v, r, lat); end
    checks++;
    if (onoff_val !== 6'b111111 || next_player !== 1'b0 || player !== 1'b1) begin
      errors++; $display("FAIL fill_hold: got %b np=%b p=%b want 111111 0 1", onoff_val, next_player, player);
    end
  endtask

  task automatic test_bad_col_busy();
    logic v, r, both;
    int lat;
    int v0, r0;
    do_clear();
    do_drop(3'd7, v, r, lat, both);
    checks++;
    if (r !== 1'b1 || v !== 1'b0 || lat != 2) begin errors++; $display("FAIL badcol_reject: got v=%b r=%b lat=%0d want 0 1 2", v, r, lat); end
    checks++;
    if ({onoff_val, col_out, player, next_player} !== 11'd0) begin errors++; $display("FAIL badcol_hold: got %b want 0", {onoff_val, col_out, player, next_player}); end
    #1;
    v0 = vcnt; r0 = rcnt;
    drop_col = 3'd1;
    drop_req = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %b want 1", busy); end
    drop_req = 1'b0;
    @(negedge clock);
    drop_col = 3'd4;
    drop_req = 1'b1;
    repeat (8) @(negedge clock);
    drop_req = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (vcnt - v0 != 1 || rcnt - r0 != 0) begin errors++; $display("FAIL busy_one_pulse: got v=%0d r=%0d want 1 0", vcnt - v0, rcnt - r0); end
    checks++;
    if (col_out !== 3'd1 || onoff_val !== 6'b000001 || next_player !== 1'b1) begin
      errors++; $display("FAIL busy_result: got col %0d %b np=%b want 1 000001 1", col_out, onoff_val, next_player);
    end
  endtask

  task automatic test_board_full();
    logic v, r, both;
    int lat;
    logic [5:0] exp_occ;
    do_clear();
    for (int c = 0; c < 7; c++) begin
      exp_occ = 6'b000000;
      for (int k = 0; k < 6; k++) begin
        exp_occ = {exp_occ[4:0], 1'b1};
        if (c == 6 && k == 5) begin
          checks++;
          if (board_full !== 1'b0) begin errors++; $display("FAIL full_before: got %b want 0", board_full); end
        end
        do_drop(3'(c), v, r, lat, both);
        checks++;
        if (v !== 1'b1 || lat != 3 || onoff_val !== exp_occ) begin
          errors++; $display("FAIL full_drop_c%0d_k%0d: got v=%b lat=%0d %b want 1 3 %b", c, k, v, lat, onoff_val, exp_occ);
        end
      end
    end
    checks++;
    if (board_full !== 1'b1 || next_player !== 1'b0) begin errors++; $display("FAIL full_flag: got bf=%b np=%b want 1 0", board_full, next_player); end
`ifdef DROP_MOVE_COUNT_EN
    checks++;
    if (move_count !== 6'd42) begin errors++; $display("FAIL full_move_count: got %0d want 42", move_count); end
`endif
    do_drop(3'd4, v, r, lat, both);
    checks++;
    if (r !== 1'b1 || v !== 1'b0 || lat != 2) begin errors++; $display("FAIL full_reject: got v=%b r=%b lat=%0d want 0 1 2", v, r, lat); end
`ifdef DROP_MOVE_COUNT_EN
    checks++;
    if (move_count !== 6'd42) begin errors++; $display("FAIL full_move_hold: got %0d want 42", move_count); end
`endif
  endtask

  task automatic test_clear();
    logic v, r, both;
    int lat;
    int v0;
    #1;
    v0 = vcnt;
    @(negedge clock);
    drop_col = 3'd5;
    drop_req = 1'b1;
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    checks++;
    if (drop_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_abort: got dv=%b busy=%b want 0 0", drop_valid, busy); end
    drop_req = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (vcnt != v0) begin errors++; $display("FAIL clear_no_valid: got %0d pulses want 0", vcnt - v0); end
    checks++;
    if ({onoff_val, col_out, player, next_player, board_full} !== 12'd0) begin
      errors++; $display("FAIL clear_state: got %b want 0", {onoff_val, col_out, player, next_player, board_full});
    end
`ifdef DROP_MOVE_COUNT_EN
    checks++;
    if (move_count !== 6'd0) begin errors++; $display("FAIL clear_move_count: got %0d want 0", move_count); end
`endif
    do_drop(3'd2, v, r, lat, both);
    checks++;
    if (v !== 1'b1 || onoff_val !== 6'b000001 || player !== 1'b0 || col_out !== 3'd2) begin
      errors++; $display("FAIL clear_next_drop: got v=%b %b p=%b col %0d want 1 000001 0 2", v, onoff_val, player, col_out);
    end
    do_drop(3'd5, v, r, lat, both);
    checks++;
    if (v !== 1'b1 || onoff_val !== 6'b000001 || player !== 1'b1) begin
      errors++; $display("FAIL clear_col5: got v=%b %b p=%b want 1 000001 1", v, onoff_val, player);
    end
  endtask

  initial begin
    test_reset();
    test_single_drop();
    test_column_fill();
    test_bad_col_busy();
    test_board_full();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/column_drop_ctrl.md
# column_drop_ctrl

Game-state stage directly upstream of the row finder: accepts a player's "drop piece in column N" request, keeps the 6-bit thermometer occupancy code of every column, and on each accepted drop presents the updated occupancy code of the chosen column on `onoff_val` (bit 0 = bottom-most piece, one more bit set per piece), plus the column index and the player who moved. The downstream row finder turns `onoff_val` into the VGA row. This block also tracks whose turn it is and rejects illegal drops: column out of range, column full, or board full.

## Interface
- `NUM_COLS`, default 7: number of board columns. Legal column indices are 0..NUM_COLS-1; max 8.
- `NUM_ROWS`, default 6: column height. It sets the `onoff_val` width and is fixed at 6 to match the row finder.

- `clock` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous new-game clear; highest priority after reset.
- `drop_req` in 1: drop request level from a key. Only its rising edge starts a drop.
- `drop_col` in 3: requested column, sampled on the `drop_req` rising edge.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `drop_valid` out 1: one-cycle pulse marking an accepted drop.
- `drop_reject` out 1: one-cycle pulse marking a rejected drop.
- `onoff_val` out 6: occupancy code of the last accepted column; held until the next accepted drop.
- `col_out` out 3: column of the last accepted drop; held.
- `player` out 1: player of the last accepted drop (0/1); held.
- `next_player` out 1: player whose turn it is now.
- `board_full` out 1: high when every column equals 6'b111111.

## Operation
- **Storage:** NUM_COLS × 6-bit occupancy registers `occ[c]`, all zero after reset or clear.
- **Edge detector:** registered copy of `drop_req`. The edge condition is `drop_req & ~drop_req_q`, and it is acted on only in IDLE. Edges that arrive while `busy` is high are discarded, not queued.
- **FSM states:**
  - IDLE: on an edge, latch `drop_col` into `col_l` and go to CHECK.
  - CHECK: if `col_l >= NUM_COLS`, or `occ[col_l][5]` = 1, or `board_full`, go to REJECT. Otherwise go to WRITE.
  - WRITE: `occ[col_l] <= {occ[col_l][4:0], 1'b1}`, then go to ANNOUNCE.
  - ANNOUNCE:
    - Drive `onoff_val <= occ[col_l]` (the updated value), `col_out <= col_l`, `player <= next_player`.
    - Pulse `drop_valid`.
    - Toggle `next_player`.
    - Go to IDLE.
  - REJECT: pulse `drop_reject`. `occ`, `next_player` and all held outputs are unchanged. Go to IDLE.
- **`board_full`:** combinational AND of all `occ[c][5]`.
- **`clear`:** takes effect from any state. It zeroes `occ`, the held outputs and `next_player`, sets the FSM to IDLE, and suppresses pulses in that cycle. A drop in progress when `clear` asserts is abandoned.
- **Reset values:**
  - FSM = IDLE.
  - `busy` = 0, `drop_valid` = 0, `drop_reject` = 0.
  - `onoff_val` = 6'b000000, `col_out` = 0.
  - `player` = 0, `next_player` = 0.
  - `board_full` = 0, edge register = 0.
- **Reset mid-operation:** same as reset; no pulse is emitted.

## Timing
- Cycle 0: `drop_req` rising edge seen at the clock edge; the FSM enters CHECK.
- Accepted drop:
  - Cycle 1: CHECK.
  - Cycle 2: WRITE.
  - Cycle 3: ANNOUNCE; `drop_valid` is high for exactly this cycle, and `onoff_val`/`col_out`/`player` are valid from this cycle onward.
  - Total latency from the rising edge to `drop_valid`: 3 cycles.
- Rejected drop: cycle 1 CHECK, cycle 2 REJECT with `drop_reject` high; latency 2 cycles.
- `busy` is high from cycle 1 until the cycle after the pulse. The earliest next edge is accepted in the cycle the FSM is back in IDLE.
- `drop_valid` and `drop_reject` are never high together.

## Configuration
- Macro: `DROP_MOVE_COUNT_EN`.
- **Defined:**
  - Adds output `move_count` [5:0]: the number of accepted drops since reset/clear, range 0..42.
  - It increments in the ANNOUNCE cycle, saturates at NUM_COLS*NUM_ROWS, and is reset/cleared to 0.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert `resetn`=0 mid-drop (CHECK state), then release. Required: all outputs zero, FSM IDLE, no `drop_valid`/`drop_reject` pulse.
- **Single drop:** edge on `drop_req` with `drop_col`=3. Required: `drop_valid` 3 cycles later, `onoff_val`=6'b000001, `col_out`=3, `player`=0, `next_player`=1.
- **Column fill:** 7 drops into column 0.
  - Drops 1..6: `onoff_val` = 000001, 000011, 000111, 001111, 011111, 111111, with `player` alternating 0,1,0,1,0,1.
  - Drop 7: `drop_reject` 2 cycles after the edge; `onoff_val` stays 111111 and `next_player` stays 0.
- **Bad column and busy:**
  - `drop_col`=7: `drop_reject`, no state change.
  - A second edge while `busy`=1: ignored; exactly one pulse results.
- **Board full:** 42 legal drops across columns 0..6. Required: `board_full`=1 after the 42nd `drop_valid`; any further drop gives `drop_reject`; with `DROP_MOVE_COUNT_EN` defined, `move_count`=42.
- **Clear:** `clear` asserted during WRITE. Required: no `drop_valid`, all `occ`=0, `next_player`=0; the next drop into column 2 gives `onoff_val`=000001 and `player`=0.
